// File: rtl/gt_trigger_gen_pkg.sv
// Shared definitions for the global-time trigger generator and related time-window logic.
package gt_trigger_gen_pkg;

    localparam int GT_W = 22;
    localparam int PH_W = 3;
    localparam logic [GT_W-1:0] HALF_RANGE = {1'b1, {(GT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

endpackage

// File: rtl/gt_reached.sv
// Modular comparison of a free-running global-time counter against a target value.
module gt_reached
    import gt_trigger_gen_pkg::*;
(
    input  logic [GT_W-1:0] now,
    input  logic [GT_W-1:0] tgt,
    output logic            reached,
    output logic            late
);

    logic [GT_W-1:0] d_ahead;
    logic [GT_W-1:0] d_behind;

    // Half-range windows make both tests robust to wrap and to counter jumps.
    always_comb begin
        d_ahead  = tgt - now;
        d_behind = now - tgt;
        reached  = d_behind < HALF_RANGE;
        late     = (d_ahead == '0) || (d_ahead >= HALF_RANGE);
    end

endmodule

// File: rtl/gt_trigger_gen.sv
// Turns an armed global-time target into a fixed-width trigger pulse, with optional periodic re-arm.
module gt_trigger_gen
    import gt_trigger_gen_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GT_W-1:0]   gtin,
    input  logic [GT_W+2:0]   target,
    input  logic [GT_W-1:0]   period,
    input  logic              arm,
    input  logic              cancel,
    output logic              trig,
    output logic [PH_W-1:0]   trig_phase,
    output logic              busy,
    output logic              done,
    output logic              late,
    output logic [CNT_W-1:0]  fire_count
);

    localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_LEN - 1);

    state_t            state_q, state_d;
    logic [GT_W-1:0]   tcnt_q, tcnt_d;
    logic [GT_W-1:0]   period_q, period_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic              trig_q, trig_d;
    logic [PH_W-1:0]   trig_phase_q, trig_phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              late_q, late_d;
    logic [CNT_W-1:0]  fc_q, fc_d;

    logic [GT_W-1:0]   cmp_tgt;
    logic              cmp_reached;
    logic              cmp_late;

    // One comparator serves all states: new request, held target, or next periodic target.
    always_comb begin
        cmp_tgt = tcnt_q;
        case (state_q)
            ST_IDLE: cmp_tgt = target[GT_W+2:3];
            ST_FIRE: cmp_tgt = tcnt_q + period_q;
            default: cmp_tgt = tcnt_q;
        endcase
    end

    gt_reached u_cmp (
        .now     (gtin),
        .tgt     (cmp_tgt),
        .reached (cmp_reached),
        .late    (cmp_late)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        period_d = period_q;
        phase_d  = phase_q;
        pcnt_d   = pcnt_q;
        trig_d   = 1'b0;
        done_d   = 1'b0;
        late_d   = late_q;
        fc_d     = fc_q;

        if (cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        tcnt_d   = target[GT_W+2:3];
                        phase_d  = target[2:0];
                        period_d = period;
                        late_d   = 1'b0;
                        fc_d     = '0;
                        if (cmp_late) begin
                            late_d = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (cmp_reached) begin
                        state_d = ST_FIRE;
                        trig_d  = 1'b1;
                        pcnt_d  = '0;
                        if (fc_q != '1) fc_d = fc_q + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (pcnt_q == PC_LAST) begin
                        if (period_q == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            tcnt_d = cmp_tgt;
                            if (cmp_late) begin
                                late_d  = 1'b1;
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_ARMED;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                        trig_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        trig_phase_d = trig_d ? phase_q : '0;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            period_q     <= '0;
            phase_q      <= '0;
            pcnt_q       <= '0;
            trig_q       <= 1'b0;
            trig_phase_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            late_q       <= 1'b0;
            fc_q         <= '0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            period_q     <= period_d;
            phase_q      <= phase_d;
            pcnt_q       <= pcnt_d;
            trig_q       <= trig_d;
            trig_phase_q <= trig_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            late_q       <= late_d;
            fc_q         <= fc_d;
        end
    end

    assign trig       = trig_q;
    assign trig_phase = trig_phase_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign late       = late_q;
    assign fire_count = fc_q;

endmodule
